id_operand_sb: RTL and testbench
================================

# id_operand_sb

Parametrised operand-resolution and hazard unit for the decode stage. It selects each source operand from an immediate, from N prioritised forwarding sources, or from the register file, and never forwards register 0. It also keeps a per-register countdown scoreboard for long-latency writers such as multi-cycle multiply and divide. From these it raises a combinational stall request on load-use, read-after-long-write and write-after-write hazards.

## Interface
Parameters:
- DATA_W, 32, operand/data width
- REG_AW, 5, register address width; scoreboard has 2**REG_AW entries
- FWD_N, 2, number of forwarding sources; index 0 = youngest stage = highest priority
- LAT_W, 6, scoreboard countdown width; max latency 2**LAT_W-1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- rd1_en, rd2_en  in  1 each  operand reads register (0 = take imm)
- rd1_addr, rd2_addr  in  REG_AW each  source register addresses
- rf_data1, rf_data2  in  DATA_W each  register-file read data
- imm  in  DATA_W  decoded immediate
- fwd_we  in  FWD_N  source i writes a register
- fwd_rdy  in  FWD_N  source i data valid (0 = load still in flight)
- fwd_addr  in  FWD_N*REG_AW  packed destination addresses, source i at [i*REG_AW +: REG_AW]
- fwd_data  in  FWD_N*DATA_W  packed data, same packing
- issue_valid  in  1  decode holds a valid instruction
- issue_wreg  in  1  instruction writes issue_wd
- issue_long  in  1  write is long-latency
- issue_wd  in  REG_AW  destination register
- issue_lat  in  LAT_W  cycles until long result reaches a forwarding source
- stall_in  in  1  downstream stall; instruction not accepted this cycle
- op1, op2  out  DATA_W  resolved operands (combinational)
- stall_req  out  1  hazard stall request (combinational)
- sb_busy  out  1  any scoreboard counter nonzero (registered state, combinational OR)

## Operation
- Operand k: rst -> 0; rd_en=0 -> imm; addr==0 -> 0; else lowest i with fwd_we[i] & fwd_addr[i]==addr -> fwd_data[i]; else rf_data.
- The matched source is the lowest index only. If that source has fwd_rdy=0, the operand is not ready, even when an older source matches with ready data.
- Scoreboard: cnt[r], LAT_W bits, for r in 1..2**REG_AW-1. pend[r] = (cnt[r]!=0). cnt[0] is held at 0.
- hazard_k = rd_en & addr!=0 & (pend[addr] | matched source has fwd_rdy=0).
- waw = issue_wreg & issue_wd!=0 & pend[issue_wd].
- stall_req = issue_valid & (hazard_1 | hazard_2 | waw); forced 0 during rst.
- accept = issue_valid & !stall_req & !stall_in.
- Per clock, every nonzero cnt decrements by 1.
- If accept & issue_wreg & issue_long & issue_wd!=0, then cnt[issue_wd] <= issue_lat. This load overrides the decrement on the same entry.
- issue_lat==0 leaves the entry unchanged. Such an issue behaves as a normal short write.
- A short write (issue_long=0) never touches the scoreboard.
- Counters saturate at 0 and never wrap.

## Timing
- op1, op2, stall_req: zero latency, combinational from the current cycle's inputs and scoreboard state.
- Scoreboard updates on the rising edge.
- An accepted long issue in cycle T with latency L makes pend=1 for cycles T+1..T+L.
- In cycle T+L+1 the register reads from forwarding or the register file. The producer must present the result on a fwd source no later than T+L+1.
- Reset: all cnt=0, sb_busy=0 from the edge sampling rst=1. op1/op2=0 and stall_req=0 while rst is high.
- Reset mid-countdown clears all pending entries immediately. Any long op in flight is discarded by its owner.
- stall_in=1 blocks the scoreboard load, while counters keep decrementing.
- Both operands on the same pending register raise a single stall_req.
- A read of a register whose counter reaches 0 on this edge is stalled this cycle and free next cycle.

## Test plan
- Reset: drive rst=1 with pend r5 set (cnt=7) -> next cycle sb_busy=0, stall_req=0, op1=op2=0; after release, reading r5 gives no stall.
- Forward priority: fwd_we=2'b11, both addr=3, data0=0xAAAA0000, data1=0x5555; rd1 r3 -> op1=0xAAAA0000. Same with addr=0 -> op1=0 (not forwarded).
- Load-use: fwd_we[0]=1, fwd_rdy[0]=0, addr=4, fwd[1] ready with r4=0x11; rd2 r4 -> stall_req=1. Next cycle fwd_rdy[0]=1, data=0x22 -> stall_req=0, op2=0x22.
- Long write: accept issue_long to r8, lat=3 at T. Read r8 -> stall_req=1 at T+1..T+3. At T+4 stall_req=0, with op from fwd/rf.
- WAW and stall_in: r9 pending (cnt=2); short write to r9 -> stall_req=1. Separately, a long issue to r10 with stall_in=1 -> cnt[r10] stays 0, sb_busy unchanged.
- Simultaneous: cnt[r6]=1 and an accepted long issue to r6 with lat=5 in the same cycle -> next cycle cnt[r6]=5. This issue is only accepted if not stalled by waw, so drive it with issue_wreg checked on the preceding cycle.

Source files
------------

// File: rtl/id_operand_sb.sv
// Decode-stage operand resolution and hazard detection.
// Picks imm / forwarded / regfile operands and tracks long-latency writers.
module id_operand_sb #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int FWD_N  = 2,
   parameter int LAT_W  = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rd1_en,
   input  logic                      rd2_en,
   input  logic [REG_AW-1:0]         rd1_addr,
   input  logic [REG_AW-1:0]         rd2_addr,
   input  logic [DATA_W-1:0]         rf_data1,
   input  logic [DATA_W-1:0]         rf_data2,
   input  logic [DATA_W-1:0]         imm,
   input  logic [FWD_N-1:0]          fwd_we,
   input  logic [FWD_N-1:0]          fwd_rdy,
   input  logic [FWD_N*REG_AW-1:0]   fwd_addr,
   input  logic [FWD_N*DATA_W-1:0]   fwd_data,
   input  logic                      issue_valid,
   input  logic                      issue_wreg,
   input  logic                      issue_long,
   input  logic [REG_AW-1:0]         issue_wd,
   input  logic [LAT_W-1:0]          issue_lat,
   input  logic                      stall_in,
   output logic [DATA_W-1:0]         op1,
   output logic [DATA_W-1:0]         op2,
   output logic                      stall_req,
   output logic                      sb_busy
);

   localparam int NREG = 2 ** REG_AW;

   logic [LAT_W-1:0]             cnt [NREG];
   logic [NREG-1:0]              pend;

   logic [1:0]                   en;
   logic [1:0][REG_AW-1:0]       addr;
   logic [1:0][DATA_W-1:0]       rf;
   logic [1:0][DATA_W-1:0]       op;
   logic [1:0][DATA_W-1:0]       fdata;
   logic [1:0]                   hit;
   logic [1:0]                   rdy;
   logic [1:0]                   hazard;
   logic                         waw;
   logic                         accept;
   logic                         sb_load;

   assign en   = {rd2_en, rd1_en};
   assign addr = {rd2_addr, rd1_addr};
   assign rf   = {rf_data2, rf_data1};

   // A register is pending while its countdown is nonzero.
   always_comb begin
      pend = '0;
      for (int r = 0; r < NREG; r++) begin
         pend[r] = (cnt[r] != '0);
      end
   end

   // Find the youngest matching forward source per operand and pick the operand.
   always_comb begin
      hit   = '0;
      rdy   = '1;
      fdata = '0;
      op    = '0;
      for (int k = 0; k < 2; k++) begin
         for (int i = FWD_N - 1; i >= 0; i--) begin
            if (fwd_we[i] && (fwd_addr[i*REG_AW +: REG_AW] == addr[k])) begin
               hit[k]   = 1'b1;
               rdy[k]   = fwd_rdy[i];
               fdata[k] = fwd_data[i*DATA_W +: DATA_W];
            end
         end
         if (rst) begin
            op[k] = '0;
         end else if (!en[k]) begin
            op[k] = imm;
         end else if (addr[k] == '0) begin
            op[k] = '0;
         end else if (hit[k]) begin
            op[k] = fdata[k];
         end else begin
            op[k] = rf[k];
         end
      end
   end

   assign op1 = op[0];
   assign op2 = op[1];

   // Hazard terms: pending long write, unready forward, or write-after-write.
   always_comb begin
      hazard = '0;
      for (int k = 0; k < 2; k++) begin
         hazard[k] = en[k] && (addr[k] != '0) &&
                     (pend[addr[k]] || (hit[k] && !rdy[k]));
      end
   end

   assign waw       = issue_wreg && (issue_wd != '0) && pend[issue_wd];
   assign stall_req = !rst && issue_valid && ((|hazard) || waw);
   assign accept    = issue_valid && !stall_req && !stall_in;
   assign sb_load   = accept && issue_wreg && issue_long &&
                      (issue_wd != '0) && (issue_lat != '0);
   assign sb_busy   = |pend;

   // Countdown scoreboard; a new long issue overrides the decrement.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            cnt[r] <= '0;
         end
      end else begin
         cnt[0] <= '0;
         for (int r = 1; r < NREG; r++) begin
            if (sb_load && (issue_wd == REG_AW'(r))) begin
               cnt[r] <= issue_lat;
            end else if (cnt[r] != '0) begin
               cnt[r] <= cnt[r] - LAT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_id_operand_sb.sv
// Directed testbench for id_operand_sb.
// Hand-computed expectations for operand select, forwarding and scoreboard.
module tb_id_operand_sb;

   logic        clk;
   logic        rst;
   logic        rd1_en, rd2_en;
   logic [4:0]  rd1_addr, rd2_addr;
   logic [31:0] rf_data1, rf_data2, imm;
   logic [1:0]  fwd_we, fwd_rdy;
   logic [9:0]  fwd_addr;
   logic [63:0] fwd_data;
   logic        issue_valid, issue_wreg, issue_long;
   logic [4:0]  issue_wd;
   logic [5:0]  issue_lat;
   logic        stall_in;
   logic [31:0] op1, op2;
   logic        stall_req, sb_busy;

   int vectors;
   int miscompares;

   id_operand_sb dut (
      .clk         (clk),
      .rst         (rst),
      .rd1_en      (rd1_en),
      .rd2_en      (rd2_en),
      .rd1_addr    (rd1_addr),
      .rd2_addr    (rd2_addr),
      .rf_data1    (rf_data1),
      .rf_data2    (rf_data2),
      .imm         (imm),
      .fwd_we      (fwd_we),
      .fwd_rdy     (fwd_rdy),
      .fwd_addr    (fwd_addr),
      .fwd_data    (fwd_data),
      .issue_valid (issue_valid),
      .issue_wreg  (issue_wreg),
      .issue_long  (issue_long),
      .issue_wd    (issue_wd),
      .issue_lat   (issue_lat),
      .stall_in    (stall_in),
      .op1         (op1),
      .op2         (op2),
      .stall_req   (stall_req),
      .sb_busy     (sb_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      rd1_en      = 1'b0;
      rd2_en      = 1'b0;
      rd1_addr    = '0;
      rd2_addr    = '0;
      rf_data1    = '0;
      rf_data2    = '0;
      imm         = '0;
      fwd_we      = '0;
      fwd_rdy     = '1;
      fwd_addr    = '0;
      fwd_data    = '0;
      issue_valid = 1'b1;
      issue_wreg  = 1'b0;
      issue_long  = 1'b0;
      issue_wd    = '0;
      issue_lat   = '0;
      stall_in    = 1'b0;
   endtask

   task automatic long_issue(input logic [4:0] wd, input logic [5:0] lat);
      issue_wreg = 1'b1;
      issue_long = 1'b1;
      issue_wd   = wd;
      issue_lat  = lat;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      idle();
      rst = 1'b1;
      step();
      step();
      chk("rst_busy", {31'b0, sb_busy}, 32'h0);
      chk("rst_stall", {31'b0, stall_req}, 32'h0);
      rst = 1'b0;

      // r5 pending with 7 cycles, then reset mid-countdown
      long_issue(5'd5, 6'd7);
      settle();
      chk("r5_issue_nostall", {31'b0, stall_req}, 32'h0);
      step();
      idle();
      rd1_en = 1'b1; rd1_addr = 5'd5;
      settle();
      chk("r5_busy", {31'b0, sb_busy}, 32'h1);
      chk("r5_stall", {31'b0, stall_req}, 32'h1);
      rst = 1'b1;
      rd1_en = 1'b0; imm = 32'hDEAD_BEEF;
      rd2_en = 1'b1; rd2_addr = 5'd5; rf_data2 = 32'h1234;
      step();
      chk("rst2_busy", {31'b0, sb_busy}, 32'h0);
      chk("rst2_stall", {31'b0, stall_req}, 32'h0);
      chk("rst2_op1", op1, 32'h0);
      chk("rst2_op2", op2, 32'h0);
      rst = 1'b0;
      idle();
      step();
      rd1_en = 1'b1; rd1_addr = 5'd5; rf_data1 = 32'h55;
      settle();
      chk("post_rst_stall", {31'b0, stall_req}, 32'h0);
      chk("post_rst_op1", op1, 32'h55);

      // forward priority, r0 never forwarded, imm and rf paths
      idle();
      fwd_we = 2'b11; fwd_addr = {5'd3, 5'd3};
      fwd_data = {32'h0000_5555, 32'hAAAA_0000};
      rd1_en = 1'b1; rd1_addr = 5'd3; rf_data1 = 32'h77;
      rd2_en = 1'b1; rd2_addr = 5'd7; rf_data2 = 32'h99;
      settle();
      chk("fwd_prio_op1", op1, 32'hAAAA_0000);
      chk("fwd_rf_op2", op2, 32'h99);
      chk("fwd_stall", {31'b0, stall_req}, 32'h0);
      fwd_we = 2'b10; fwd_addr = {5'd3, 5'd3};
      settle();
      chk("fwd_src1_op1", op1, 32'h0000_5555);
      fwd_we = 2'b11; fwd_addr = '0; rd1_addr = 5'd0;
      settle();
      chk("fwd_r0_op1", op1, 32'h0);
      rd1_en = 1'b0; imm = 32'hCAFE;
      settle();
      chk("imm_op1", op1, 32'hCAFE);

      // load-use on youngest source shadows a ready older match
      idle();
      fwd_we = 2'b11; fwd_rdy = 2'b10; fwd_addr = {5'd4, 5'd4};
      fwd_data = {32'h11, 32'h0};
      rd2_en = 1'b1; rd2_addr = 5'd4;
      settle();
      chk("loaduse_stall", {31'b0, stall_req}, 32'h1);
      step();
      fwd_rdy = 2'b11; fwd_data = {32'h11, 32'h22};
      settle();
      chk("loaduse_clear", {31'b0, stall_req}, 32'h0);
      chk("loaduse_op2", op2, 32'h22);
      issue_valid = 1'b0; fwd_rdy = 2'b10;
      settle();
      chk("loaduse_novalid", {31'b0, stall_req}, 32'h0);

      // long write r8 latency 3: stall T+1..T+3, free at T+4
      idle();
      long_issue(5'd8, 6'd3);
      step();
      idle();
      rd1_en = 1'b1; rd1_addr = 5'd8; rf_data1 = 32'h888;
      rd2_en = 1'b1; rd2_addr = 5'd8;
      settle();
      chk("long_t1", {31'b0, stall_req}, 32'h1);
      step();
      chk("long_t2", {31'b0, stall_req}, 32'h1);
      step();
      chk("long_t3", {31'b0, stall_req}, 32'h1);
      step();
      chk("long_t4", {31'b0, stall_req}, 32'h0);
      chk("long_t4_op1", op1, 32'h888);
      chk("long_t4_busy", {31'b0, sb_busy}, 32'h0);

      // WAW against a pending r9
      idle();
      long_issue(5'd9, 6'd2);
      step();
      idle();
      issue_wreg = 1'b1; issue_wd = 5'd9;
      settle();
      chk("waw_stall", {31'b0, stall_req}, 32'h1);
      idle();
      step();
      step();
      chk("waw_drain", {31'b0, sb_busy}, 32'h0);

      // stall_in blocks the load; r0 and lat=0 never load
      long_issue(5'd10, 6'd4);
      stall_in = 1'b1;
      settle();
      chk("stallin_req", {31'b0, stall_req}, 32'h0);
      step();
      chk("stallin_busy", {31'b0, sb_busy}, 32'h0);
      idle();
      long_issue(5'd0, 6'd5);
      step();
      chk("r0_busy", {31'b0, sb_busy}, 32'h0);
      idle();
      long_issue(5'd11, 6'd0);
      step();
      chk("lat0_busy", {31'b0, sb_busy}, 32'h0);

      // reissue r6 while its counter is at 1
      idle();
      long_issue(5'd6, 6'd2);
      step();
      idle();
      step();
      long_issue(5'd6, 6'd5);
      settle();
      chk("r6_cnt1_waw", {31'b0, stall_req}, 32'h1);
      step();
      chk("r6_accept", {31'b0, stall_req}, 32'h0);
      step();
      idle();
      rd1_en = 1'b1; rd1_addr = 5'd6;
      settle();
      chk("r6_lat5_t1", {31'b0, stall_req}, 32'h1);
      chk("r6_busy", {31'b0, sb_busy}, 32'h1);
      for (int i = 0; i < 4; i++) step();
      chk("r6_lat5_t5", {31'b0, stall_req}, 32'h1);
      step();
      chk("r6_lat5_t6", {31'b0, stall_req}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
